// File: rtl/seven_seg_scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment scan decoder and its encoder
// counterpart.
//   - SEG_0..SEG_F, SEG_BLANK : segment patterns, bit6..0 = g..a, active-high
//   - nibble_t                : 4-bit decoded digit value
//   - scan_state_t            : dwell-tracking FSM states
//   - seg_decode_t            : bundled result of one pattern lookup
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } scan_state_t;

  typedef struct packed {
    nibble_t nibble;
    logic    blank;
    logic    error;
  } seg_decode_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_decoder_if
// Bundles the scanned display bus (input side) and the frame handshake
// (output side) of the scan decoder. Signal names are from the decoder's
// point of view.
//   i_SEVEN_SEG  [6:0]            segment pattern, g..a
//   i_DIGIT_SEL  [NUM_DIGITS-1:0] one-hot digit enable
//   i_READY                       consumer accepts frame
//   o_VALUE      [4*NUM_DIGITS-1:0] decoded frame, digit i at [4i+3:4i]
//   o_BLANK_MASK [NUM_DIGITS-1:0] digit showed all-off
//   o_ERROR                       frame had an undecodable pattern
//   o_VALID                       frame available
//   o_OVERRUN                     one-cycle pulse, completed frame dropped
// Modports: slave = decoder, master = display/consumer side.
// ---------------------------------------------------------------------------
interface seven_seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);

  logic [6:0]              i_SEVEN_SEG;
  logic [NUM_DIGITS-1:0]   i_DIGIT_SEL;
  logic                    i_READY;
  logic [4*NUM_DIGITS-1:0] o_VALUE;
  logic [NUM_DIGITS-1:0]   o_BLANK_MASK;
  logic                    o_ERROR;
  logic                    o_VALID;
  logic                    o_OVERRUN;

  modport slave (
    input  i_SEVEN_SEG,
    input  i_DIGIT_SEL,
    input  i_READY,
    output o_VALUE,
    output o_BLANK_MASK,
    output o_ERROR,
    output o_VALID,
    output o_OVERRUN
  );

  modport master (
    output i_SEVEN_SEG,
    output i_DIGIT_SEL,
    output i_READY,
    input  o_VALUE,
    input  o_BLANK_MASK,
    input  o_ERROR,
    input  o_VALID,
    input  o_OVERRUN
  );

endinterface

// File: rtl/seven_seg_scan_decoder_pattern_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_pattern_decoder
// Combinational inverse of the hex seven-segment encoder.
//   i_SEG    [6:0] segment pattern, g..a, active-high
//   o_NIBBLE [3:0] decoded value (0 when blank or undecodable)
//   o_BLANK        pattern was all-off
//   o_ERROR        pattern is not one of the 16 hex glyphs nor blank
// ---------------------------------------------------------------------------
module seven_seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_SEG,
  output nibble_t    o_NIBBLE,
  output logic       o_BLANK,
  output logic       o_ERROR
);

  always_comb begin
    o_NIBBLE = 4'h0;
    o_BLANK  = 1'b0;
    o_ERROR  = 1'b0;
    case (i_SEG)
      SEG_0:     o_NIBBLE = 4'h0;
      SEG_1:     o_NIBBLE = 4'h1;
      SEG_2:     o_NIBBLE = 4'h2;
      SEG_3:     o_NIBBLE = 4'h3;
      SEG_4:     o_NIBBLE = 4'h4;
      SEG_5:     o_NIBBLE = 4'h5;
      SEG_6:     o_NIBBLE = 4'h6;
      SEG_7:     o_NIBBLE = 4'h7;
      SEG_8:     o_NIBBLE = 4'h8;
      SEG_9:     o_NIBBLE = 4'h9;
      SEG_A:     o_NIBBLE = 4'hA;
      SEG_B:     o_NIBBLE = 4'hB;
      SEG_C:     o_NIBBLE = 4'hC;
      SEG_D:     o_NIBBLE = 4'hD;
      SEG_E:     o_NIBBLE = 4'hE;
      SEG_F:     o_NIBBLE = 4'hF;
      SEG_BLANK: o_BLANK  = 1'b1;
      default:   o_ERROR  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_decoder
// Watches a multiplexed seven-segment bus, waits for each digit dwell to be
// stable, decodes it back to a nibble and assembles a full frame, which is
// offered on a valid/ready handshake.
//
// Ports:
//   i_CLK  system clock
//   i_RST  synchronous active-high reset
//   bus    seven_seg_scan_decoder_if.slave (segment bus in, frame out)
//
// Parameters:
//   NUM_DIGITS    digits per scan frame (1..8)
//   STABLE_CYCLES identical consecutive samples required to capture (>=2)
//
// Build option:
//   SEG_ACTIVE_LOW_EN  invert segment and select lines at the input register
//                      (common-anode boards). Undefined: active-high.
//
// Dwell FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | select zero or multi-hot, counter held at 0
//   SETTLE   | counting identical samples of select+pattern
//   CAPTURED | digit stored, waiting for the dwell to end
// ---------------------------------------------------------------------------
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  seven_seg_scan_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // input stage
  logic [6:0]            w_seg_in;
  logic [NUM_DIGITS-1:0] w_sel_in;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [6:0]            r_seg_d;
  logic [NUM_DIGITS-1:0] r_sel_d;

`ifdef SEG_ACTIVE_LOW_EN
  // Register holds the polarity-corrected value, so its reset value of 0
  // corresponds to an all-ones raw bus (blank, no digit selected).
  assign w_seg_in = ~bus.i_SEVEN_SEG;
  assign w_sel_in = ~bus.i_DIGIT_SEL;
`else
  assign w_seg_in = bus.i_SEVEN_SEG;
  assign w_sel_in = bus.i_DIGIT_SEL;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_seg   <= '0;
      r_sel   <= '0;
      r_seg_d <= '0;
      r_sel_d <= '0;
    end else begin
      r_seg   <= w_seg_in;
      r_sel   <= w_sel_in;
      r_seg_d <= r_seg;
      r_sel_d <= r_sel;
    end
  end

  logic w_same;
  logic w_onehot;

  assign w_same   = (r_seg == r_seg_d) && (r_sel == r_sel_d);
  assign w_onehot = $onehot(r_sel);

  // dwell FSM
  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_capture;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The sample that first shows a one-hot select (or a changed one) counts
  // as sample 1, so the capture lands STABLE_CYCLES+1 clocks after the bus
  // edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_next = SETTLE;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (w_same) begin
          w_cnt_next = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_state_next = CAPTURED;
          end
        end else if (w_onehot) begin
          w_cnt_next = CNT_ONE;
        end else begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      CAPTURED: begin
        if (!w_same) begin
          if (w_onehot) begin
            w_state_next = SETTLE;
            w_cnt_next   = CNT_ONE;
          end else begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    if ((r_state == SETTLE) && w_same && (r_cnt == CNT_LAST)) begin
      w_capture = 1'b1;
    end
  end

  // pattern lookup on the registered bus
  nibble_t w_nib;
  logic    w_blank;
  logic    w_err;

  seven_seg_pattern_decoder u_pattern_decoder (
    .i_SEG    (r_seg),
    .o_NIBBLE (w_nib),
    .o_BLANK  (w_blank),
    .o_ERROR  (w_err)
  );

  // frame assembly
  logic [4*NUM_DIGITS-1:0] r_val_buf;
  logic [NUM_DIGITS-1:0]   r_blank_buf;
  logic [NUM_DIGITS-1:0]   r_err_buf;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic                    r_pend;
  logic                    w_frame_done;

  assign w_frame_done = w_capture && ((r_mask | r_sel) == '1);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_val_buf   <= '0;
      r_blank_buf <= '0;
      r_err_buf   <= '0;
      r_mask      <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_pend <= w_frame_done;
      // Publish cycle clears the accumulators; a capture cannot coincide
      // with it because a new dwell needs at least STABLE_CYCLES clocks.
      if (r_pend) begin
        r_mask    <= '0;
        r_err_buf <= '0;
      end else if (w_capture) begin
        r_mask <= r_mask | r_sel;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && r_sel[i]) begin
          r_val_buf[4*i +: 4] <= w_nib;
          r_blank_buf[i]      <= w_blank;
          r_err_buf[i]        <= w_err;
        end
      end
    end
  end

  // output handshake
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_blank_mask;
  logic                    r_error;
  logic                    r_valid;
  logic                    r_overrun;
  logic                    w_can_load;

  // A held frame may be replaced in the same cycle it is transferred.
  assign w_can_load = !r_valid || bus.i_READY;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_value      <= '0;
      r_blank_mask <= '0;
      r_error      <= 1'b0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= r_pend && !w_can_load;
      if (r_pend && w_can_load) begin
        r_value      <= r_val_buf;
        r_blank_mask <= r_blank_buf;
        r_error      <= |r_err_buf;
        r_valid      <= 1'b1;
      end else if (r_valid && bus.i_READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_VALUE      = r_value;
  assign bus.o_BLANK_MASK = r_blank_mask;
  assign bus.o_ERROR      = r_error;
  assign bus.o_VALID      = r_valid;
  assign bus.o_OVERRUN    = r_overrun;

endmodule
